// File: rtl/mem_arb32.sv
// Two-master arbiter (instruction fetch, load/store unit) onto one memory port.
// Round-robin on ties, one outstanding transaction, per-transaction timeout.
module mem_arb32 #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ifu_req,
  input  logic [WIDTH-1:0] ifu_addr,
  output logic             ifu_gnt,
  output logic             ifu_rvalid,
  output logic [WIDTH-1:0] ifu_rdata,
  output logic             ifu_err,
  input  logic             lsu_req,
  input  logic             lsu_we,
  input  logic [WIDTH-1:0] lsu_addr,
  input  logic [WIDTH-1:0] lsu_wdata,
  input  logic [3:0]       lsu_wmask,
  output logic             lsu_gnt,
  output logic             lsu_rvalid,
  output logic [WIDTH-1:0] lsu_rdata,
  output logic             lsu_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state;
  owner_t     owner;
  owner_t     last_owner;
  logic [7:0] count;
  logic       ifu_win;
  logic       lsu_win;
  logic       expire;

  // Grants are combinational so a requester is accepted in the same cycle it is seen.
  always_comb begin
    ifu_win = 1'b0;
    lsu_win = 1'b0;
    if (state == IDLE) begin
      ifu_win = ifu_req && (!lsu_req || last_owner == OWN_LSU);
      lsu_win = lsu_req && (!ifu_req || last_owner == OWN_IFU);
    end
  end

  assign ifu_gnt = ifu_win;
  assign lsu_gnt = lsu_win;
  assign expire  = (count + 8'd1) == TIMEOUT_C;

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_IFU;
      last_owner <= OWN_IFU;
      count      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      ifu_rvalid <= 1'b0;
      ifu_rdata  <= '0;
      ifu_err    <= 1'b0;
      lsu_rvalid <= 1'b0;
      lsu_rdata  <= '0;
      lsu_err    <= 1'b0;
    end else begin
      ifu_rvalid <= 1'b0;
      lsu_rvalid <= 1'b0;
      ifu_err    <= 1'b0;
      lsu_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_win) begin
            state      <= BUSY;
            owner      <= OWN_LSU;
            last_owner <= OWN_LSU;
            count      <= '0;
            mem_req    <= 1'b1;
            mem_we     <= lsu_we;
            mem_addr   <= lsu_addr;
            mem_wdata  <= lsu_wdata;
            mem_wmask  <= lsu_wmask;
          end else if (ifu_win) begin
            state      <= BUSY;
            owner      <= OWN_IFU;
            last_owner <= OWN_IFU;
            count      <= '0;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= ifu_addr;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
          end
        end
        BUSY: begin
          // An ack wins over an expiry landing on the same cycle.
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (owner == OWN_IFU) begin
              ifu_rvalid <= 1'b1;
              ifu_rdata  <= mem_rdata;
            end else begin
              lsu_rvalid <= 1'b1;
              lsu_rdata  <= mem_we ? '0 : mem_rdata;
            end
          end else if (expire) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            count   <= count + 8'd1;
            if (owner == OWN_IFU) begin
              ifu_rvalid <= 1'b1;
              ifu_err    <= 1'b1;
              ifu_rdata  <= '0;
            end else begin
              lsu_rvalid <= 1'b1;
              lsu_err    <= 1'b1;
              lsu_rdata  <= '0;
            end
          end else begin
            count <= count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
